adc_capture_readout: RTL and testbench
======================================

// Module: adc_capture_readout
// PURPOSE
//  Downstream stage of the ADC capture path. Waits for the receive interrupt from the capture writer,
//  then reads the captured 128-bit words (8 ch x 12-bit samples in 16-bit lanes) back from capture RAM
//  port B and streams them in address order over a valid/ready interface toward the HPS transfer logic.
//  Absorbs RAM read latency and downstream backpressure with a small FIFO; signals completion.
// PARAMETERS
//  RD_LAT      2      capture RAM read latency in clocks, from oRdEn/oRAddr to iRData valid
//  FIFO_DEPTH  4      output buffer depth in words; must be >= RD_LAT+2
//  MAX_WORDS   16384  capture RAM depth in words; recording length is clamped to this
// PORTS
//  adc_clkinp        in   1    block clock (same domain as capture writer)
//  iStateReset       in   1    async active-high reset
//  iRcvInterrupt     in   8    capture-complete interrupt from writer; start = rising edge of |iRcvInterrupt
//  iRecLength        in   16   words to read; sampled at start only
//  oRdEn             out  1    RAM port B read enable
//  oRAddr            out  15   RAM port B read address
//  iRData            in   128  RAM port B read data, valid RD_LAT clocks after oRdEn
//  oData             out  128  stream data word
//  oValid            out  1    stream valid
//  iReady            in   1    stream ready from consumer
//  oLast             out  1    high with the final word of the record
//  oBusy             out  1    readout in progress
//  oDone             out  1    one-clock pulse when final word is accepted
//  oChecksum         out  16   record checksum (RDOUT_CHKSUM_EN only; else tied 0)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; FIFO empty; in-flight reads discarded; interrupt edge detector cleared.
//  FSM IDLE -> READ on start edge; len = min(iRecLength, MAX_WORDS) latched; if len==0 go DONE directly.
//  READ: issue oRdEn=1 with oRAddr=rd_ptr (0..len-1) on any cycle where
//        inflight + fifo_count < FIFO_DEPTH; rd_ptr++ per issue; -> DRAIN after issuing addr len-1.
//  DRAIN: no reads; wait until all issued words are accepted downstream -> DONE.
//  DONE: oDone=1 for exactly one clock (the cycle after last handshake), oBusy=0 -> IDLE.
//  Start edges while not IDLE are ignored; the edge detector holds no pending start.
//  Level-held interrupt does not retrigger; it must drop to 0 and rise again.
//  Returned words enter FIFO RD_LAT clocks after issue, in issue order; FIFO never overflows (credit rule).
//  Stream: word transfers when oValid&&iReady; oData/oLast stable while oValid&&!iReady;
//        first word earliest RD_LAT+1 clocks after start edge; with iReady=1 throughput 1 word/clk.
//  oLast=1 only on word index len-1; oBusy=1 from clock after start edge through DRAIN.
//  Address counter is 16-bit internally so len=16384 terminates without wrap; oRAddr = low 15 bits.
// CONFIGURATION
//  `RDOUT_CHKSUM_EN defined: oChecksum = sum mod 2^16 of all 12-bit samples (lanes [16k+11:16k])
//        of all words accepted downstream; cleared at start edge; final value valid when oDone pulses
//        and held until next start edge or reset.
//  Undefined: no accumulator logic; oChecksum constant 0.
// STRUCTURE
//  Package adc_rdout_pkg: FSM state enum (IDLE, READ, DRAIN, DONE), WORD_W=128, ADDR_W=15,
//        LANE_W=16, SAMPLE_W=12, N_CH=8.
//  Sub-module rdout_fifo: synchronous FIFO, FIFO_DEPTH x 128, push/pop/count, async reset.
//  Top holds FSM, address/credit counters, RD_LAT-deep valid shift pipe, edge detect, checksum.
// TESTING
//  len=4, iReady=1, RAM word n = {8{16'(n+1)}} -> reads addr 0..3, oData words 1..4 in order, oLast on 4th, oDone 1 clk later.
//  len=8, iReady toggling 1/0 each clk -> 8 words, no loss/duplication, data held while stalled, never >FIFO_DEPTH outstanding.
//  len=0 -> no oRdEn, no oValid, oDone pulses once, oBusy returns 0.
//  iRecLength=20000 -> exactly 16384 reads, addr 16383 last, oLast on 16384th word, no address wrap.
//  iStateReset asserted mid-record (after word 5 of 10) -> outputs 0 immediately; next start edge reads from addr 0.
//  `RDOUT_CHKSUM_EN, len=2, all samples 12'hFFF -> oChecksum = 16*4095 mod 65536 = 16'hFFF0 at oDone.
//  Second interrupt edge while busy -> ignored; one record only.

Source files
------------

// File: rtl/adc_rdout_pkg.sv
// Shared types and constants for the ADC capture readout path.
// The optional RDOUT_CHKSUM_EN build uses word_sample_sum() below.
package adc_rdout_pkg;

   localparam int unsigned WORD_W   = 128;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned LANE_W   = 16;
   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned N_CH     = 8;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRead  = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   // Sum of the 12-bit samples in one captured word, modulo 2^16.
   function automatic logic [15:0] word_sample_sum(input logic [WORD_W-1:0] w);
      logic [15:0] s;
      s = '0;
      for (int k = 0; k < int'(N_CH); k++) begin
         s = s + 16'(w[k*LANE_W +: SAMPLE_W]);
      end
      return s;
   endfunction

endpackage

// File: rtl/rdout_fifo.sv
// Synchronous output buffer for the readout stream: push/pop/count, async active-high reset.
module rdout_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 128,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      do_push = push && (count_q != CNT_W'(DEPTH));
      do_pop  = pop && (count_q != '0);
      rdata   = mem_q[rd_ptr_q];
      count   = count_q;
      empty   = (count_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/adc_capture_readout.sv
// Reads a captured record back from capture RAM port B and streams it out over valid/ready.
// Optional record checksum when RDOUT_CHKSUM_EN is defined.
module adc_capture_readout
   import adc_rdout_pkg::*;
#(
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned MAX_WORDS  = 16384
) (
   input  logic              adc_clkinp,
   input  logic              iStateReset,
   input  logic [7:0]        iRcvInterrupt,
   input  logic [15:0]       iRecLength,
   output logic              oRdEn,
   output logic [ADDR_W-1:0] oRAddr,
   input  logic [WORD_W-1:0] iRData,
   output logic [WORD_W-1:0] oData,
   output logic              oValid,
   input  logic              iReady,
   output logic              oLast,
   output logic              oBusy,
   output logic              oDone,
   output logic [15:0]       oChecksum
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned INF_W = $clog2(RD_LAT + 1);

   logic [1:0]        state_q, state_d;
   logic              irq_q, start;
   logic [15:0]       len_q, len_d, start_len;
   logic [15:0]       rd_ptr_q, rd_ptr_d;
   logic [15:0]       out_cnt_q, out_cnt_d;
   logic [RD_LAT-1:0] rd_pipe_q;
   logic [INF_W-1:0]  inflight_q, inflight_d;
   logic              rd_en, fifo_push, accept;
   logic [WORD_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;

   rdout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk   (adc_clkinp),
      .rst   (iStateReset),
      .push  (fifo_push),
      .wdata (iRData),
      .pop   (accept),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   always_comb begin
      start     = (|iRcvInterrupt) && !irq_q;
      start_len = (32'(iRecLength) > MAX_WORDS) ? 16'(MAX_WORDS) : iRecLength;
      // Credit rule: every issued read already owns a FIFO slot, so the FIFO cannot overflow.
      rd_en     = (state_q == StRead) &&
                  ((32'(inflight_q) + 32'(fifo_count)) < FIFO_DEPTH);
      fifo_push = rd_pipe_q[RD_LAT-1];
      oValid    = !fifo_empty;
      accept    = oValid && iReady;
      oData     = oValid ? fifo_rdata : '0;
      oLast     = oValid && (out_cnt_q == len_q - 16'd1);
      oRdEn     = rd_en;
      oRAddr    = rd_en ? rd_ptr_q[ADDR_W-1:0] : '0;
      oBusy     = (state_q == StRead) || (state_q == StDrain);
      oDone     = (state_q == StDone);

      inflight_d = inflight_q + INF_W'(rd_en) - INF_W'(fifo_push);
      state_d    = state_q;
      len_d      = len_q;
      rd_ptr_d   = rd_ptr_q;
      out_cnt_d  = out_cnt_q + 16'(accept);

      case (state_q)
         StIdle: begin
            if (start) begin
               len_d     = start_len;
               rd_ptr_d  = '0;
               out_cnt_d = '0;
               state_d   = (start_len == '0) ? StDone : StRead;
            end
         end
         StRead: begin
            if (rd_en) begin
               rd_ptr_d = rd_ptr_q + 16'd1;
               if (rd_ptr_q == len_q - 16'd1) state_d = StDrain;
            end
         end
         StDrain: begin
            if (accept && oLast) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge adc_clkinp or posedge iStateReset) begin
      if (iStateReset) begin
         state_q    <= StIdle;
         irq_q      <= 1'b0;
         len_q      <= '0;
         rd_ptr_q   <= '0;
         out_cnt_q  <= '0;
         rd_pipe_q  <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         irq_q      <= |iRcvInterrupt;
         len_q      <= len_d;
         rd_ptr_q   <= rd_ptr_d;
         out_cnt_q  <= out_cnt_d;
         inflight_q <= inflight_d;
         for (int i = int'(RD_LAT) - 1; i > 0; i--) rd_pipe_q[i] <= rd_pipe_q[i-1];
         rd_pipe_q[0] <= rd_en;
      end
   end

`ifdef RDOUT_CHKSUM_EN
   logic [15:0] chk_q;

   always_ff @(posedge adc_clkinp or posedge iStateReset) begin
      if (iStateReset) begin
         chk_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         chk_q <= '0;
      end else if (accept) begin
         chk_q <= chk_q + word_sample_sum(fifo_rdata);
      end
   end

   assign oChecksum = chk_q;
`else
   assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_adc_capture_readout.sv
// Directed self-checking bench for adc_capture_readout with a RD_LAT=2 capture RAM model.
module tb_adc_capture_readout;

   localparam int FIFO_DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   irq;
   logic [15:0]  rec_len;
   logic         rd_en;
   logic [14:0]  raddr;
   logic [127:0] rdata;
   logic [127:0] odata;
   logic         ovalid, ready, olast, obusy, odone;
   logic [15:0]  ochk;

   always #5 clk = ~clk;

   adc_capture_readout dut (
      .adc_clkinp    (clk),
      .iStateReset   (rst),
      .iRcvInterrupt (irq),
      .iRecLength    (rec_len),
      .oRdEn         (rd_en),
      .oRAddr        (raddr),
      .iRData        (rdata),
      .oData         (odata),
      .oValid        (ovalid),
      .iReady        (ready),
      .oLast         (olast),
      .oBusy         (obusy),
      .oDone         (odone),
      .oChecksum     (ochk)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RAM model: word n = {8{n+1}} or, in mode 1, every sample 12'hFFF.
   bit           ram_mode = 0;
   logic [127:0] ram_p0 = '0, ram_p1 = '0;

   function automatic logic [127:0] pattern(input int n);
      logic [15:0] v;
      v = ram_mode ? 16'h0FFF : 16'(n + 1);
      return {8{v}};
   endfunction

   always @(posedge clk) begin
      ram_p0 <= rd_en ? pattern(int'(raddr)) : '0;
      ram_p1 <= ram_p0;
   end
   assign rdata = ram_p1;

   // Stream / read monitor
   int           cyc = 0;
   int           cur_len = 0;
   int           exp_addr = 0;
   int           n_reads = 0, n_words = 0, n_valid = 0, n_last = 0, n_done = 0;
   int           last_addr = -1, last_hs_cyc = 0;
   logic [15:0]  chk_at_done = '0;
   bit           prev_stall = 0;
   logic [127:0] prev_data;
   logic         prev_last;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", ovalid, 1'b1);
            check("stall_data", odata, prev_data);
            check("stall_last", olast, prev_last);
         end
         if (rd_en) begin
            check("rd_addr", raddr, 15'(exp_addr));
            last_addr = int'(raddr);
            exp_addr++;
            n_reads++;
         end
         if (ovalid) n_valid++;
         if (ovalid && ready) begin
            check("data", odata, pattern(n_words));
            check("last_flag", olast, n_words == cur_len - 1);
            if (olast) begin
               n_last++;
               last_hs_cyc = cyc;
            end
            n_words++;
         end
         check("outstanding", (n_reads - n_words) <= FIFO_DEPTH, 1'b1);
         if (odone) begin
            n_done++;
            chk_at_done = ochk;
            if (cur_len != 0) check("done_timing", cyc, last_hs_cyc + 1);
         end
         prev_stall = ovalid && !ready;
         prev_data  = odata;
         prev_last  = olast;
      end
   end

   task automatic start_rec(input int len, input int clamped, input bit mode);
      @(posedge clk); #1;
      ram_mode = mode;
      cur_len  = clamped;
      exp_addr = 0;
      n_reads  = 0;
      n_words  = 0;
      n_valid  = 0;
      n_last   = 0;
      rec_len  = 16'(len);
      irq      = 8'h01;
   endtask

   task automatic wait_done(input int budget, input bit toggle);
      int d0 = n_done;
      int k  = 0;
      while (n_done == d0 && k < budget) begin
         @(posedge clk); #1;
         ready = toggle ? ~ready : 1'b1;
         @(negedge clk);
         k++;
      end
      check("done_seen", n_done != d0, 1'b1);
      @(posedge clk); #1;
      ready = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rden"}, rd_en, 1'b0);
      check({tag, "_valid"}, ovalid, 1'b0);
      check({tag, "_data"}, odata, '0);
      check({tag, "_last"}, olast, 1'b0);
      check({tag, "_busy"}, obusy, 1'b0);
      check({tag, "_done"}, odone, 1'b0);
      check({tag, "_chk"}, ochk, 16'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int d0;
      rst = 1'b1; irq = '0; rec_len = '0; ready = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // len=4, ready held high; interrupt left high after completion
      start_rec(4, 4, 0);
      @(negedge clk); check("busy_at_edge", obusy, 1'b0);
      @(negedge clk); check("busy_after_edge", obusy, 1'b1);
      wait_done(40, 0);
      check("l4_reads", n_reads, 4);
      check("l4_words", n_words, 4);
      check("l4_last", n_last, 1);
      repeat (5) @(negedge clk);
      check("level_no_retrigger", n_reads, 4);
      check("l4_busy_end", obusy, 1'b0);
      irq = '0;

      // len=8 with ready toggling every clock
      start_rec(8, 8, 0);
      ready = 1'b0;
      wait_done(80, 1);
      check("l8_reads", n_reads, 8);
      check("l8_words", n_words, 8);
      check("l8_last", n_last, 1);
      irq = '0;

      // len=0
      d0 = n_done;
      start_rec(0, 0, 0);
      wait_done(10, 0);
      repeat (3) @(negedge clk);
      check("l0_reads", n_reads, 0);
      check("l0_valid", n_valid, 0);
      check("l0_done_once", n_done - d0, 1);
      check("l0_busy", obusy, 1'b0);
      irq = '0;

      // second edge while busy is ignored
      d0 = n_done;
      start_rec(6, 6, 0);
      repeat (2) @(posedge clk);
      #1 irq = '0;
      @(posedge clk); #1 irq = 8'h80;
      wait_done(60, 0);
      repeat (10) @(negedge clk);
      check("busy_edge_reads", n_reads, 6);
      check("busy_edge_done", n_done - d0, 1);
      check("busy_edge_idle", obusy, 1'b0);
      irq = '0;

      // length clamp
      start_rec(20000, 16384, 0);
      wait_done(17000, 0);
      check("clamp_reads", n_reads, 16384);
      check("clamp_words", n_words, 16384);
      check("clamp_last_addr", last_addr, 16383);
      check("clamp_last", n_last, 1);
      irq = '0;

      // reset in the middle of a 10-word record
      begin
         int k = 0;
         start_rec(10, 10, 0);
         while (n_words < 5 && k < 50) begin
            @(negedge clk);
            k++;
         end
         check("mid_reached", n_words >= 5, 1'b1);
         @(posedge clk); #1 rst = 1'b1;
         #1 check_outputs_zero("midreset");
         irq = '0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         repeat (2) @(posedge clk);
      end
      start_rec(3, 3, 0);
      wait_done(40, 0);
      check("after_reset_reads", n_reads, 3);
      check("after_reset_words", n_words, 3);
      irq = '0;

      // checksum, all samples 12'hFFF
      start_rec(2, 2, 1);
      wait_done(40, 0);
`ifdef RDOUT_CHKSUM_EN
      check("chk_at_done", chk_at_done, 16'hFFF0);
      repeat (3) @(negedge clk);
      check("chk_held", ochk, 16'hFFF0);
`else
      check("chk_at_done", chk_at_done, 16'h0000);
      repeat (3) @(negedge clk);
      check("chk_held", ochk, 16'h0000);
`endif
      irq = '0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
